// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   This block lets two requesters share one APB master port. Grants are
//   round-robin. The APB outputs are registered and go through the usual
//   IDLE -> SETUP -> ACCESS sequence.
//
//   Optional feature: APB_ARB_TIMEOUT_EN
//     When this macro is defined, an ACCESS phase that has spent
//     TIMEOUT_CYCLES cycles with PREADY low is abandoned. The requester then
//     gets reqN_done together with reqN_err=1.
//     When the macro is undefined, ACCESS waits for PREADY indefinitely.
//
//   Requester handshake: reqN_valid rises together with the request fields.
//   reqN_write, reqN_addr and reqN_wdata must stay stable while reqN_valid is
//   high, and reqN_valid stays high until reqN_done is seen. reqN_done is a
//   one-cycle pulse. reqN_rdata and reqN_err are valid in that cycle and are
//   held until the next completion for that requester. While reqN_done is high
//   the requester's valid is masked, so a requester that still holds valid in
//   the done cycle is not granted a second time.
//
//   Ports
//     PCLK, PRESETn         clock; asynchronous active-low reset
//     reqN_valid/write/addr/wdata   requester N (N = 0, 1) request
//     reqN_done/rdata/err           requester N completion
//     PSEL PENABLE PWRITE PADDR PWDATA   registered APB master outputs
//     PRDATA PREADY PSLVERR              APB slave response
//     state_dbg             current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
module apb_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_check
        $error("apb_master_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state, state_n;
    logic                  grant, grant_n;           // requester owning the current transfer
    logic                  last_grant, last_grant_n; // 1 = requester 1 was granted last
    logic                  psel_n, penable_n, pwrite_n;
    logic [ADDR_WIDTH-1:0] paddr_n;
    logic [DATA_WIDTH-1:0] pwdata_n;
    logic                  done0_n, done1_n, err0_n, err1_n;
    logic [DATA_WIDTH-1:0] rdata0_n, rdata1_n;
    logic                  v0, v1, pick;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
`endif

    // Mask a requester that is still seeing its own done pulse.
    assign v0   = req0_valid & ~req0_done;
    assign v1   = req1_valid & ~req1_done;
    // When both requesters are valid, the one not granted last wins.
    assign pick = (v0 & v1) ? ~last_grant : v1;

    assign state_dbg = state;

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        psel_n       = PSEL;
        penable_n    = PENABLE;
        pwrite_n     = PWRITE;
        paddr_n      = PADDR;
        pwdata_n     = PWDATA;
        done0_n      = 1'b0;
        done1_n      = 1'b0;
        rdata0_n     = req0_rdata;
        rdata1_n     = req1_rdata;
        err0_n       = req0_err;
        err1_n       = req1_err;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_n        = cnt;
`endif
        case (state)
            IDLE: begin
                if (v0 | v1) begin
                    grant_n      = pick;
                    last_grant_n = pick;
                    psel_n       = 1'b1;
                    penable_n    = 1'b0;
                    pwrite_n     = pick ? req1_write : req0_write;
                    paddr_n      = pick ? req1_addr  : req0_addr;
                    pwdata_n     = pick ? req1_wdata : req0_wdata;
                    state_n      = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_n     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    state_n   = IDLE;
                    if (grant) begin
                        done1_n = 1'b1;
                        err1_n  = PSLVERR;
                        if (!PWRITE) rdata1_n = PRDATA;
                    end else begin
                        done0_n = 1'b1;
                        err0_n  = PSLVERR;
                        if (!PWRITE) rdata0_n = PRDATA;
                    end
                end
`ifdef APB_ARB_TIMEOUT_EN
                // This cycle is the TIMEOUT_CYCLES-th wait cycle: give up.
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    state_n   = IDLE;
                    if (grant) begin
                        done1_n = 1'b1;
                        err1_n  = 1'b1;
                    end else begin
                        done0_n = 1'b1;
                        err0_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_n   = IDLE;
                psel_n    = 1'b0;
                penable_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            PSEL       <= psel_n;
            PENABLE    <= penable_n;
            PWRITE     <= pwrite_n;
            PADDR      <= paddr_n;
            PWDATA     <= pwdata_n;
            req0_done  <= done0_n;
            req1_done  <= done1_n;
            req0_rdata <= rdata0_n;
            req1_rdata <= rdata1_n;
            req0_err   <= err0_n;
            req1_err   <= err1_n;
`ifdef APB_ARB_TIMEOUT_EN
            cnt        <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Testbench for apb_master_arbiter.
// Inputs are driven and outputs are sampled on the falling edge of PCLK.
module tb_apb_master_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic [31:0] req0_rdata, req1_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_arbiter dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req_v);
        end
    endtask

    // driver
    task automatic drive_req(input logic r, input logic v, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
        if (r) begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
        end
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        repeat (2) tick();
        PRESETn = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        req;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic found;
        int   who, n_wait;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h24, 32'h1234,     32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h30, 32'h0,        32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'h34, 32'h0,        32'h0F0F0F0F, 1'b0, 32'h0F0F0F0F, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 32'h12345678, 1'b1, 32'hCAFEF00D, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h44, 32'h0,        32'h00000000, 1'b0, 32'h00000000, 1'b0};

        PRESETn = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
        repeat (3) tick();

        // reset state
        check("rst_psel",    PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite",  PWRITE, 1'b0);
        check("rst_paddr",   PADDR, 32'h0);
        check("rst_pwdata",  PWDATA, 32'h0);
        check("rst_done0",   req0_done, 1'b0);
        check("rst_done1",   req1_done, 1'b0);
        check("rst_rdata0",  req0_rdata, 32'h0);
        check("rst_rdata1",  req1_rdata, 32'h0);
        check("rst_err0",    req0_err, 1'b0);
        check("rst_err1",    req1_err, 1'b0);
        check("rst_state",   state_dbg, 2'd0);
        PRESETn = 1'b1;
        tick();

        // table-driven single transfers, zero wait states
        for (int i = 0; i < 6; i++) begin
            drive_req(vecs[i].req, 1'b1, vecs[i].write, vecs[i].addr, vecs[i].wdata);
            tick();
            check($sformatf("v%0d_setup_psel", i), PSEL, 1'b1);
            check($sformatf("v%0d_setup_penable", i), PENABLE, 1'b0);
            check($sformatf("v%0d_paddr", i), PADDR, vecs[i].addr);
            check($sformatf("v%0d_pwrite", i), PWRITE, vecs[i].write);
            if (vecs[i].write) check($sformatf("v%0d_pwdata", i), PWDATA, vecs[i].wdata);
            check($sformatf("v%0d_setup_state", i), state_dbg, 2'd1);
            PREADY = 1'b1; PRDATA = vecs[i].prdata; PSLVERR = vecs[i].slverr;
            tick();
            check($sformatf("v%0d_access_psel", i), PSEL, 1'b1);
            check($sformatf("v%0d_access_penable", i), PENABLE, 1'b1);
            check($sformatf("v%0d_access_nodone", i), vecs[i].req ? req1_done : req0_done, 1'b0);
            tick();
            check($sformatf("v%0d_done", i), vecs[i].req ? req1_done : req0_done, 1'b1);
            check($sformatf("v%0d_other_done", i), vecs[i].req ? req0_done : req1_done, 1'b0);
            check($sformatf("v%0d_rdata", i), vecs[i].req ? req1_rdata : req0_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), vecs[i].req ? req1_err : req0_err, vecs[i].exp_err);
            check($sformatf("v%0d_end_psel", i), PSEL, 1'b0);
            check($sformatf("v%0d_end_penable", i), PENABLE, 1'b0);
            drive_req(vecs[i].req, 1'b0, 1'b0, 32'h0, 32'h0);
            PREADY = 1'b0; PSLVERR = 1'b0;
            tick();
            check($sformatf("v%0d_done_pulse", i), vecs[i].req ? req1_done : req0_done, 1'b0);
        end

        // wait states: write held across 4 PREADY-low ACCESS cycles; valid is
        // dropped after SETUP and the transfer must still complete
        drive_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h55);
        tick();
        check("ws_setup_psel", PSEL, 1'b1);
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ws_stable%0d", i),
                  {PSEL, PENABLE, PWRITE, req0_done, PADDR, PWDATA},
                  {1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h55});
            if (i == 4) PREADY = 1'b1;
            tick();
        end
        check("ws_done", req0_done, 1'b1);
        check("ws_err", req0_err, 1'b0);
        check("ws_rdata_kept", req0_rdata, 32'h0);
        check("ws_psel_low", PSEL, 1'b0);
        PREADY = 1'b0;

        // contention after reset: both held, grants alternate starting with req0
        do_reset();
        drive_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        drive_req(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        PREADY = 1'b1; PRDATA = 32'h11;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            who = 0;
            for (int k = 0; k < 8 && !found; k++) begin
                tick();
                if (req0_done | req1_done) begin
                    found = 1'b1;
                    who = req1_done ? 1 : 0;
                    check($sformatf("cont%0d_single_done", g), req0_done & req1_done, 1'b0);
                end
            end
            check($sformatf("cont%0d_done_seen", g), found, 1'b1);
            check($sformatf("cont%0d_winner", g), who, g % 2);
            if (g == 3) drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (g == 3) drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            check($sformatf("cont%0d_one_cycle", g), req0_done | req1_done, 1'b0);
        end
        PREADY = 1'b0;
        tick();
        check("cont_idle_psel", PSEL, 1'b0);

        // stalled slave, then reset in the middle of ACCESS
        drive_req(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        PRDATA = 32'hBAD0BAD0;
        tick();
        check("stall_setup", PSEL, 1'b1);
`ifdef APB_ARB_TIMEOUT_EN
        n_wait = 0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (req1_done) found = 1'b1;
            else if (PENABLE) n_wait++;
        end
        check("to_done_seen", found, 1'b1);
        check("to_wait_cycles", n_wait, 16);
        check("to_err", req1_err, 1'b1);
        check("to_rdata_kept", req1_rdata, 32'h11);
        check("to_psel_low", PSEL, 1'b0);
        // valid is still held, so a new transfer starts; wait for its ACCESS
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (PENABLE) found = 1'b1;
        end
        check("to_regrant", found, 1'b1);
`else
        n_wait = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (req0_done | req1_done) n_wait++;
        end
        check("stall_no_done", n_wait, 0);
        check("stall_still_access", {PSEL, PENABLE}, 2'b11);
`endif
        #2 PRESETn = 1'b0;
        #1;
        check("arst_psel", PSEL, 1'b0);
        check("arst_penable", PENABLE, 1'b0);
        check("arst_state", state_dbg, 2'd0);
        tick();
        check("arst_no_done", req1_done, 1'b0);
        PRESETn = 1'b1;
        PRDATA = 32'h600DD00D;
        tick();
        check("post_rst_psel", PSEL, 1'b1);
        check("post_rst_paddr", PADDR, 32'h300);
        PREADY = 1'b1;
        tick();
        check("post_rst_penable", PENABLE, 1'b1);
        tick();
        check("post_rst_done1", req1_done, 1'b1);
        check("post_rst_done0", req0_done, 1'b0);
        check("post_rst_rdata", req1_rdata, 32'h600DD00D);
        check("post_rst_err", req1_err, 1'b0);
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        PREADY = 1'b0;
        tick();

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
